// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - machine-mode trap entry/MRET sequencer owning the CSR write port
module trap_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            irq_timer,
  input  logic            irq_ext,
  input  logic [XLEN-1:0] mstatus,
  input  logic [XLEN-1:0] mie,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] mepc,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] pc_ex,
  input  logic            is_mret,
  input  logic            pipe_csr_wr,
  input  logic [11:0]     pipe_csr_addr,
  input  logic [XLEN-1:0] pipe_csr_wdata,
  output logic            csr_wr,
  output logic [11:0]     csr_addr,
  output logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] mip_out,
  output logic            stall,
  output logic            flush,
  output logic            pc_redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic            trap_taken
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_T_EPC    = 3'd1;
  localparam logic [2:0] S_T_CAUSE  = 3'd2;
  localparam logic [2:0] S_T_STATUS = 3'd3;
  localparam logic [2:0] S_T_REDIR  = 3'd4;
  localparam logic [2:0] S_M_STATUS = 3'd5;
  localparam logic [2:0] S_M_REDIR  = 3'd6;

  logic [2:0]      state, state_nxt;
  logic [XLEN-1:0] lat_pc, lat_status, lat_vec;
  logic            lat_ext;
  logic            ext_hit, pending, take, do_mret;
  logic [XLEN-1:0] trap_cause, entry_status, exit_status, vec_base, trap_target;
  logic            unused_bits;

  assign unused_bits = ^{mie[31:12], mie[10:8], mie[6:0]};

  assign ext_hit = irq_ext & mie[11];
  assign pending = ext_hit | (irq_timer & mie[7]);
  assign take    = (state == S_IDLE) & ex_valid & mstatus[3] & pending;
  assign do_mret = (state == S_IDLE) & ex_valid & is_mret & ~take;

  // lat_vec holds mtvec for a trap and mepc for an MRET; only one is live at a time.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      lat_pc     <= '0;
      lat_status <= '0;
      lat_vec    <= '0;
      lat_ext    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (take) begin
        lat_pc     <= pc_ex;
        lat_ext    <= ext_hit;
        lat_status <= mstatus;
        lat_vec    <= mtvec;
      end else if (do_mret) begin
        lat_status <= mstatus;
        lat_vec    <= mepc;
      end
    end
  end

  assign trap_cause   = lat_ext ? 32'h8000_000B : 32'h8000_0007;
  assign entry_status = {lat_status[31:13], 2'b11, lat_status[10:8], lat_status[3],
                         lat_status[6:4], 1'b0, lat_status[2:0]};
  assign exit_status  = {lat_status[31:8], 1'b1, lat_status[6:4], lat_status[7], lat_status[2:0]};
  assign vec_base     = {lat_vec[31:2], 2'b00};
  assign trap_target  = (lat_vec[1:0] == 2'b01) ? vec_base + {26'b0, trap_cause[3:0], 2'b00}
                                                : vec_base;

  always_comb begin
    state_nxt   = state;
    csr_wr      = 1'b0;
    csr_addr    = '0;
    csr_wdata   = '0;
    stall       = 1'b1;
    flush       = 1'b0;
    pc_redirect = 1'b0;
    redirect_pc = '0;
    trap_taken  = 1'b0;
    mip_out     = {20'b0, irq_ext, 3'b0, irq_timer, 7'b0};
    case (state)
      S_IDLE: begin
        if (take) begin
          flush     = 1'b1;
          state_nxt = S_T_EPC;
        end else if (do_mret) begin
          flush     = 1'b1;
          state_nxt = S_M_STATUS;
        end else begin
          stall     = 1'b0;
          csr_wr    = pipe_csr_wr;
          csr_addr  = pipe_csr_wr ? pipe_csr_addr : 12'h0;
          csr_wdata = pipe_csr_wr ? pipe_csr_wdata : '0;
        end
      end
      S_T_EPC: begin
        csr_wr    = 1'b1;
        csr_addr  = 12'h341;
        csr_wdata = lat_pc;
        state_nxt = S_T_CAUSE;
      end
      S_T_CAUSE: begin
        csr_wr    = 1'b1;
        csr_addr  = 12'h342;
        csr_wdata = trap_cause;
        state_nxt = S_T_STATUS;
      end
      S_T_STATUS: begin
        csr_wr    = 1'b1;
        csr_addr  = 12'h300;
        csr_wdata = entry_status;
        state_nxt = S_T_REDIR;
      end
      S_T_REDIR: begin
        pc_redirect = 1'b1;
        redirect_pc = trap_target;
        trap_taken  = 1'b1;
        state_nxt   = S_IDLE;
      end
      S_M_STATUS: begin
        csr_wr    = 1'b1;
        csr_addr  = 12'h300;
        csr_wdata = exit_status;
        state_nxt = S_M_REDIR;
      end
      S_M_REDIR: begin
        pc_redirect = 1'b1;
        redirect_pc = lat_vec;
        state_nxt   = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    // Reset forces every output low at once, even mid-sequence.
    if (!rst) begin
      csr_wr      = 1'b0;
      csr_addr    = '0;
      csr_wdata   = '0;
      stall       = 1'b0;
      flush       = 1'b0;
      pc_redirect = 1'b0;
      redirect_pc = '0;
      trap_taken  = 1'b0;
      mip_out     = '0;
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// tb/tb_trap_ctrl.sv - vector table, directed sequences and randomized model check for trap_ctrl
module tb_trap_ctrl;

  typedef struct packed {
    logic        wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        flush;
    logic        redir;
    logic [31:0] rpc;
    logic        trap;
  } exp_t;

  typedef struct {
    logic        it, ie;
    logic [31:0] mst, mie_v;
    logic        ev, mret, pwr;
    logic [11:0] pa;
    logic [31:0] pd;
    exp_t        e;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        irq_timer, irq_ext, ex_valid, is_mret, pipe_csr_wr;
  logic [31:0] mstatus, mie, mtvec, mepc, pc_ex, pipe_csr_wdata;
  logic [11:0] pipe_csr_addr;
  logic        csr_wr, stall, flush, pc_redirect, trap_taken;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata, mip_out, redirect_pc;
  exp_t        got;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  trap_ctrl #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .irq_timer(irq_timer), .irq_ext(irq_ext),
    .mstatus(mstatus), .mie(mie), .mtvec(mtvec), .mepc(mepc),
    .ex_valid(ex_valid), .pc_ex(pc_ex), .is_mret(is_mret),
    .pipe_csr_wr(pipe_csr_wr), .pipe_csr_addr(pipe_csr_addr), .pipe_csr_wdata(pipe_csr_wdata),
    .csr_wr(csr_wr), .csr_addr(csr_addr), .csr_wdata(csr_wdata), .mip_out(mip_out),
    .stall(stall), .flush(flush), .pc_redirect(pc_redirect), .redirect_pc(redirect_pc),
    .trap_taken(trap_taken)
  );

  assign got = {csr_wr, csr_addr, csr_wdata, stall, flush, pc_redirect, redirect_pc, trap_taken};

  function automatic exp_t o_none();
    exp_t e = '0;
    return e;
  endfunction

  function automatic exp_t o_flush();
    exp_t e = '0;
    e.stall = 1'b1;
    e.flush = 1'b1;
    return e;
  endfunction

  function automatic exp_t o_wr(input logic [11:0] a, input logic [31:0] d);
    exp_t e = '0;
    e.wr = 1'b1; e.addr = a; e.wdata = d; e.stall = 1'b1;
    return e;
  endfunction

  function automatic exp_t o_redir(input logic [31:0] pc, input logic trap);
    exp_t e = '0;
    e.stall = 1'b1; e.redir = 1'b1; e.rpc = pc; e.trap = trap;
    return e;
  endfunction

  function automatic exp_t o_pass(input logic w, input logic [11:0] a, input logic [31:0] d);
    exp_t e = '0;
    if (w) begin
      e.wr = 1'b1; e.addr = a; e.wdata = d;
    end
    return e;
  endfunction

  // Inputs are driven just after posedge; outputs are checked at the following negedge.
  task automatic cyc(input string nm, input exp_t e);
    logic [31:0] mip_exp;
    @(negedge clk);
    mip_exp = rst ? (32'(irq_ext) << 11) | (32'(irq_timer) << 7) : 32'h0;
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL %s: outputs got %h expected %h (wr,addr,wdata,stall,flush,redir,rpc,trap)", nm, got, e);
    end
    checks++;
    if (mip_out !== mip_exp) begin
      errors++;
      $display("FAIL %s_mip: mip_out got %h expected %h", nm, mip_out, mip_exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    irq_timer = 0; irq_ext = 0; ex_valid = 0; is_mret = 0; pipe_csr_wr = 0;
    mstatus = 0; mie = 0; mtvec = 0; mepc = 0; pc_ex = 0; pipe_csr_addr = 0; pipe_csr_wdata = 0;
  endtask

  exp_t mq[$];

  // Reference: a detected event expands into the list of cycles it must produce.
  function automatic exp_t model_step();
    logic        ext, pend;
    logic [31:0] cause, st, base, tgt;
    if (!rst) begin
      mq.delete();
      return o_none();
    end
    if (mq.size() != 0) return mq.pop_front();
    ext  = irq_ext & mie[11];
    pend = ext | (irq_timer & mie[7]);
    if (ex_valid && mstatus[3] && pend) begin
      cause = ext ? 32'h8000000B : 32'h80000007;
      st = mstatus;
      st[7] = mstatus[3];
      st[3] = 1'b0;
      st[12:11] = 2'b11;
      base = mtvec & ~32'h3;
      tgt = (mtvec[1:0] == 2'b01) ? base + (cause & 32'hF) * 4 : base;
      mq.push_back(o_wr(12'h341, pc_ex));
      mq.push_back(o_wr(12'h342, cause));
      mq.push_back(o_wr(12'h300, st));
      mq.push_back(o_redir(tgt, 1'b1));
      return o_flush();
    end
    if (ex_valid && is_mret) begin
      st = mstatus;
      st[3] = mstatus[7];
      st[7] = 1'b1;
      mq.push_back(o_wr(12'h300, st));
      mq.push_back(o_redir(mepc, 1'b0));
      return o_flush();
    end
    return o_pass(pipe_csr_wr, pipe_csr_addr, pipe_csr_wdata);
  endfunction

  vec_t vt[8];

  initial begin
    vt[0] = '{1'b0, 1'b0, 32'h8, 32'h80, 1'b1, 1'b0, 1'b1, 12'h304, 32'h80, o_pass(1, 12'h304, 32'h80)};
    vt[1] = '{1'b1, 1'b0, 32'h0, 32'h80, 1'b1, 1'b0, 1'b1, 12'h304, 32'h80, o_pass(1, 12'h304, 32'h80)};
    vt[2] = '{1'b1, 1'b0, 32'h8, 32'h80, 1'b0, 1'b0, 1'b1, 12'h304, 32'h80, o_pass(1, 12'h304, 32'h80)};
    vt[3] = '{1'b1, 1'b1, 32'h8, 32'h0, 1'b1, 1'b0, 1'b0, 12'h0, 32'h0, o_none()};
    vt[4] = '{1'b1, 1'b0, 32'h8, 32'h800, 1'b1, 1'b0, 1'b1, 12'h305, 32'hDEAD, o_pass(1, 12'h305, 32'hDEAD)};
    vt[5] = '{1'b0, 1'b1, 32'h8, 32'h80, 1'b1, 1'b0, 1'b0, 12'h341, 32'h1234, o_none()};
    vt[6] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 12'h300, 32'h5, o_pass(1, 12'h300, 32'h5)};
    vt[7] = '{1'b0, 1'b1, 32'hFFFFFFF7, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 12'h7FF, 32'hFFFFFFFF,
              o_pass(1, 12'h7FF, 32'hFFFFFFFF)};

    rst = 1'b0;
    idle_in();
    pipe_csr_wr = 1; pipe_csr_addr = 12'h304; pipe_csr_wdata = 32'h80;
    cyc("reset", o_none());
    rst = 1'b1;
    idle_in();
    cyc("idle", o_none());

    for (int i = 0; i < 8; i++) begin
      irq_timer = vt[i].it; irq_ext = vt[i].ie; mstatus = vt[i].mst; mie = vt[i].mie_v;
      ex_valid = vt[i].ev; is_mret = vt[i].mret; pipe_csr_wr = vt[i].pwr;
      pipe_csr_addr = vt[i].pa; pipe_csr_wdata = vt[i].pd;
      cyc($sformatf("vec%0d", i), vt[i].e);
    end

    idle_in();
    mstatus = 32'h8; mie = 32'h80; irq_timer = 1; ex_valid = 1; pc_ex = 32'h100; mtvec = 32'h1000;
    pipe_csr_wr = 1; pipe_csr_addr = 12'h304; pipe_csr_wdata = 32'h80;
    cyc("timer_detect", o_flush());
    mstatus = 32'h1880; mtvec = 32'h0; pc_ex = 32'h999;
    cyc("timer_mepc", o_wr(12'h341, 32'h100));
    cyc("timer_mcause", o_wr(12'h342, 32'h80000007));
    cyc("timer_mstatus", o_wr(12'h300, 32'h1880));
    cyc("timer_redir", o_redir(32'h1000, 1'b1));
    cyc("timer_idle", o_pass(1, 12'h304, 32'h80));

    idle_in();
    mstatus = 32'h8; mie = 32'h880; irq_timer = 1; irq_ext = 1; ex_valid = 1; pc_ex = 32'h100; mtvec = 32'h1001;
    cyc("vec_detect", o_flush());
    mstatus = 32'h0;
    cyc("vec_mepc", o_wr(12'h341, 32'h100));
    cyc("vec_mcause", o_wr(12'h342, 32'h8000000B));
    cyc("vec_mstatus", o_wr(12'h300, 32'h1880));
    cyc("vec_redir", o_redir(32'h102C, 1'b1));
    cyc("vec_idle", o_none());

    idle_in();
    mstatus = 32'h1880; mepc = 32'h104; ex_valid = 1; is_mret = 1;
    cyc("mret_detect", o_flush());
    is_mret = 0; mepc = 32'h0; mstatus = 32'h0;
    cyc("mret_mstatus", o_wr(12'h300, 32'h1888));
    cyc("mret_redir", o_redir(32'h104, 1'b0));
    cyc("mret_idle", o_none());

    idle_in();
    mstatus = 32'h8; mie = 32'h80; irq_timer = 1; ex_valid = 1; is_mret = 1; pc_ex = 32'h200;
    mtvec = 32'h2000; mepc = 32'h500;
    cyc("both_detect", o_flush());
    mstatus = 32'h0; is_mret = 0;
    cyc("both_mepc", o_wr(12'h341, 32'h200));
    cyc("both_mcause", o_wr(12'h342, 32'h80000007));
    cyc("both_mstatus", o_wr(12'h300, 32'h1880));
    cyc("both_redir", o_redir(32'h2000, 1'b1));
    cyc("both_idle", o_none());

    idle_in();
    mstatus = 32'h8; mie = 32'h80; irq_timer = 1; ex_valid = 1; pc_ex = 32'h300; mtvec = 32'h3000;
    cyc("rst_detect", o_flush());
    mstatus = 32'h0;
    cyc("rst_mepc", o_wr(12'h341, 32'h300));
    rst = 1'b0;
    cyc("rst_abort", o_none());
    rst = 1'b1;
    cyc("rst_after1", o_none());
    cyc("rst_after2", o_none());
    mstatus = 32'h8;
    cyc("rst_retake", o_flush());
    mstatus = 32'h0;
    cyc("rst_re_mepc", o_wr(12'h341, 32'h300));
    cyc("rst_re_mcause", o_wr(12'h342, 32'h80000007));
    cyc("rst_re_mstatus", o_wr(12'h300, 32'h1880));
    cyc("rst_re_redir", o_redir(32'h3000, 1'b1));
    cyc("rst_re_idle", o_none());

    mq.delete();
    for (int n = 0; n < 3000; n++) begin
      rst            = ($urandom_range(0, 99) != 0);
      irq_timer      = ($urandom_range(0, 3) == 0);
      irq_ext        = ($urandom_range(0, 3) == 0);
      ex_valid       = ($urandom_range(0, 3) != 0);
      is_mret        = ($urandom_range(0, 6) == 0);
      mstatus        = $urandom;
      mie            = $urandom;
      mtvec          = $urandom;
      mepc           = $urandom;
      pc_ex          = $urandom;
      pipe_csr_wr    = $urandom_range(0, 1);
      pipe_csr_addr  = 12'($urandom);
      pipe_csr_wdata = $urandom;
      cyc($sformatf("rand%0d", n), model_step());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
